alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Multi-cycle initiator that drives the datapath ALU: it accepts an operation request, reads operands from an internal register file, issues them with an opcode to the ALU, and captures the ALU result and status.
- It then writes the result back and returns a response.
- It sits between instruction control and the combinational ALU.
- The ALU computes `alu_out` from `alu_ain`, `alu_bin` and `alu_op`, with status ordered {Z,V,N}.

Parameters:
- DATA_W, 16, operand/result width; it must match the ALU.
- NREGS, 8, register-file depth; a power of two; the index width is log2(NREGS).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  a request is present.
- req_ready  out  1  the sequencer can accept a request.
- req_op  in  2  ALU opcode: 00 ADD, 01 SUB, 10 AND, 11 NOT-B.
- req_rn  in  3  source A register index.
- req_rm  in  3  source B register index.
- req_rd  in  3  destination register index.
- req_wb  in  1  1 = write the result to rd.
- req_shift  in  2  B-operand shift code; used only with the optional feature.
- wr_en  in  1  external register write (loads constants).
- wr_addr  in  3  external write index.
- wr_data  in  16  external write data.
- alu_ain  out  16  ALU A operand, driven from register A.
- alu_bin  out  16  ALU B operand, driven from register B.
- alu_op  out  2  ALU opcode, driven from the latched opcode.
- alu_out  in  16  ALU result.
- alu_status  in  3  ALU status {Z,V,N}.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  16  latched result (register C).
- rsp_status  out  3  latched status.
- busy  out  1  state is not IDLE.

Behaviour:
- FSM states: IDLE, LOADA, LOADB, EXEC, WRITE, RESP.
- Reset (any state, including mid-operation) moves the FSM to IDLE and clears all of the following to 0:
  - registers A, B and C;
  - the opcode latch;
  - rsp_status, rsp_valid, busy;
  - all register-file entries.
- req_ready = (state==IDLE) && !wr_en; this is a combinational output.
- IDLE: when req_valid && req_ready, latch op/rn/rm/rd/wb/shift and go to LOADA. Otherwise stay.
- External write: wr_en in IDLE writes wr_data to reg[wr_addr] at the clock edge, and no request is accepted that cycle. wr_en outside IDLE is ignored (no write).
- LOADA: A <= reg[rn]; go to LOADB.
- LOADB: B <= reg[rm], shifted if the feature is enabled; go to EXEC.
- EXEC: alu_op = latched op; C <= alu_out; rsp_status <= alu_status; go to WRITE.
- alu_ain/alu_bin/alu_op always reflect A, B and the opcode latch; the ALU is sampled only in EXEC.
- WRITE: if wb, reg[rd] <= C; go to RESP. If wb=0, there is no write (a compare-style operation).
- RESP: rsp_valid=1. When rsp_ready is sampled high, go to IDLE, with rsp_valid=0 in the following cycle.
- rsp_result and rsp_status hold their values until the next EXEC.
- Latency from accept to rsp_valid: 5 cycles. Back-to-back throughput is 1 operation per 6 cycles if rsp_ready is held high.
- Register aliasing: rn==rm==rd is legal. Reads use the register values as of LOADA and LOADB respectively.
- A write-back in WRITE is visible to the next request's LOADA.
- Requests arriving while busy are not accepted; req_valid must hold until accepted.
- Arithmetic is modulo 2^16. No flags are generated here; status comes only from the ALU.

Optional Feature:
- Macro ALU_SEQ_SHIFTER_EN.
- When defined, in LOADB, B <= shift(reg[rm]) according to the latched req_shift:
  - 00 no shift;
  - 01 logical shift left 1, LSB=0;
  - 10 logical shift right 1, MSB=0;
  - 11 arithmetic shift right 1, MSB replicated.
- When undefined, req_shift is ignored and B <= reg[rm] unshifted; all other behaviour is identical.

Test Plan:
- Reset mid-EXEC -> next cycle: state IDLE, rsp_valid=0, busy=0, req_ready=1, every register reads 0 after reloading via a test op.
- Write R0=5, R1=3. Then request ADD rn=0 rm=1 rd=2 wb=1 -> rsp_valid 5 cycles after accept, rsp_result=8, status Z=0 N=0. A follow-up ADD rn=2 rm=2 gives 16.
- R0=3, R1=5. Request SUB rn=0 rm=1 wb=0 -> rsp_result=0xFFFE, N=1 from the ALU status. rd is unchanged.
- Hold rsp_ready=0 for 4 cycles in RESP -> rsp_valid stays 1, the result is stable, and req_ready=0. The sequencer returns to IDLE one cycle after rsp_ready=1.
- wr_en asserted during LOADA targeting R3 -> R3 is unchanged. wr_en and req_valid together in IDLE -> the write occurs and the request is not accepted that cycle.
- With ALU_SEQ_SHIFTER_EN: R1=0x8001, shift=11, NOT-B op -> B=0xC000, rsp_result=0x3FFF. Without the macro -> rsp_result=0x7FFE.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: request, external-write, ALU and response signals of
// the ALU operation sequencer. The master modport is the controller/ALU side;
// the slave modport is the sequencer itself.
interface alu_op_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
);
  localparam int IW = $clog2(NREGS);

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [IW-1:0]     req_rn;
  logic [IW-1:0]     req_rm;
  logic [IW-1:0]     req_rd;
  logic              req_wb;
  logic [1:0]        req_shift;

  logic              wr_en;
  logic [IW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic [DATA_W-1:0] alu_ain;
  logic [DATA_W-1:0] alu_bin;
  logic [1:0]        alu_op;
  logic [DATA_W-1:0] alu_out;
  logic [2:0]        alu_status;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic [2:0]        rsp_status;
  logic              busy;

  modport master (
    output req_valid, req_op, req_rn, req_rm, req_rd, req_wb, req_shift,
    input  req_ready,
    output wr_en, wr_addr, wr_data,
    input  alu_ain, alu_bin, alu_op,
    output alu_out, alu_status,
    input  rsp_valid, rsp_result, rsp_status, busy,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_op, req_rn, req_rm, req_rd, req_wb, req_shift,
    output req_ready,
    input  wr_en, wr_addr, wr_data,
    output alu_ain, alu_bin, alu_op,
    input  alu_out, alu_status,
    output rsp_valid, rsp_result, rsp_status, busy,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle initiator for a combinational ALU. Reads two
// operands from an internal register file, issues them with an opcode,
// captures result/status, optionally writes back and returns a response.
// Optional macro ALU_SEQ_SHIFTER_EN: shift the B operand in LOADB by req_shift.
module alu_op_sequencer #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              reset,
  alu_op_sequencer_if.slave bus
);
  localparam int IW = $clog2(NREGS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOADA = 3'd1,
    LOADB = 3'd2,
    EXEC  = 3'd3,
    WRITE = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] c_q, c_d;
  logic [1:0]        op_q, op_d;
  logic [IW-1:0]     rn_q, rn_d;
  logic [IW-1:0]     rm_q, rm_d;
  logic [IW-1:0]     rd_q, rd_d;
  logic              wb_q, wb_d;
  logic [2:0]        status_q, status_d;
  logic [DATA_W-1:0] rf_q [NREGS];
  logic [DATA_W-1:0] rf_d [NREGS];
  logic [DATA_W-1:0] b_load;

`ifdef ALU_SEQ_SHIFTER_EN
  logic [1:0]        shift_q, shift_d;

  function automatic logic [DATA_W-1:0] shift_b(input logic [DATA_W-1:0] v,
                                                 input logic [1:0]        code);
    case (code)
      2'b01:   return {v[DATA_W-2:0], 1'b0};
      2'b10:   return {1'b0, v[DATA_W-1:1]};
      2'b11:   return {v[DATA_W-1], v[DATA_W-1:1]};
      default: return v;
    endcase
  endfunction

  // B operand as loaded in LOADB: register rm shifted by the latched code
  always_comb begin
    b_load = shift_b(rf_q[rm_q], shift_q);
  end
`else
  logic unused_shift;
  assign unused_shift = ^bus.req_shift;

  // B operand as loaded in LOADB: register rm unshifted
  always_comb begin
    b_load = rf_q[rm_q];
  end
`endif

  // Next-state, operand/result capture and register-file update
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    op_d     = op_q;
    rn_d     = rn_q;
    rm_d     = rm_q;
    rd_d     = rd_q;
    wb_d     = wb_q;
    status_d = status_q;
    rf_d     = rf_q;
`ifdef ALU_SEQ_SHIFTER_EN
    shift_d  = shift_q;
`endif
    case (state_q)
      IDLE: begin
        // an external write takes the cycle; req_ready is low so no accept
        if (bus.wr_en) begin
          rf_d[bus.wr_addr] = bus.wr_data;
        end else if (bus.req_valid) begin
          op_d    = bus.req_op;
          rn_d    = bus.req_rn;
          rm_d    = bus.req_rm;
          rd_d    = bus.req_rd;
          wb_d    = bus.req_wb;
`ifdef ALU_SEQ_SHIFTER_EN
          shift_d = bus.req_shift;
`endif
          state_d = LOADA;
        end
      end
      LOADA: begin
        a_d     = rf_q[rn_q];
        state_d = LOADB;
      end
      LOADB: begin
        b_d     = b_load;
        state_d = EXEC;
      end
      EXEC: begin
        c_d      = bus.alu_out;
        status_d = bus.alu_status;
        state_d  = WRITE;
      end
      WRITE: begin
        if (wb_q) begin
          rf_d[rd_q] = c_q;
        end
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      op_q     <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      rd_q     <= '0;
      wb_q     <= 1'b0;
      status_q <= '0;
      rf_q     <= '{default: '0};
`ifdef ALU_SEQ_SHIFTER_EN
      shift_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      op_q     <= op_d;
      rn_q     <= rn_d;
      rm_q     <= rm_d;
      rd_q     <= rd_d;
      wb_q     <= wb_d;
      status_q <= status_d;
      rf_q     <= rf_d;
`ifdef ALU_SEQ_SHIFTER_EN
      shift_q  <= shift_d;
`endif
    end
  end

  // Outputs decoded from state and the held registers
  always_comb begin
    bus.req_ready  = (state_q == IDLE) && !bus.wr_en;
    bus.busy       = (state_q != IDLE);
    bus.rsp_valid  = (state_q == RESP);
    bus.rsp_result = c_q;
    bus.rsp_status = status_q;
    bus.alu_ain    = a_q;
    bus.alu_bin    = b_q;
    bus.alu_op     = op_q;
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and randomized checks of alu_op_sequencer
// against a register-array reference model and a behavioural ALU.
module tb_alu_op_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.DATA_W(16), .NREGS(8)) bus ();

  alu_op_sequencer #(.DATA_W(16), .NREGS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [15:0] ref_rf [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural ALU: returns {Z,V,N, result}
  function automatic logic [18:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] op);
    logic [15:0] r;
    logic        v;
    v = 1'b0;
    case (op)
      2'd0: begin
        r = a + b;
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      2'd1: begin
        r = a - b;
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      2'd2:    r = a & b;
      default: r = ~b;
    endcase
    return {(r == 16'd0), v, r[15], r};
  endfunction

  function automatic logic [15:0] shift_ref(input logic [15:0] v, input logic [1:0] code);
`ifdef ALU_SEQ_SHIFTER_EN
    case (code)
      2'd1:    return v * 16'd2;
      2'd2:    return v / 16'd2;
      2'd3:    return (v / 16'd2) | (v & 16'h8000);
      default: return v;
    endcase
`else
    if (code == 2'd0) return v;
    return v;
`endif
  endfunction

  always_comb begin
    {bus.alu_status, bus.alu_out} = alu_ref(bus.alu_ain, bus.alu_bin, bus.alu_op);
  end

  task automatic ext_write(input logic [2:0] addr, input logic [15:0] data);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    #1 check("req_ready_during_wr", bus.req_ready, 1'b0);
    @(negedge clk);
    bus.wr_en = 1'b0;
    ref_rf[addr] = data;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [2:0] rn, input logic [2:0] rm,
                        input logic [2:0] rd, input logic wb, input logic [1:0] sh,
                        input int hold, input logic poke);
    logic [18:0] e;
    int          lat;
    e = alu_ref(ref_rf[rn], shift_ref(ref_rf[rm], sh), op);
    @(negedge clk);
    check("req_ready_idle", bus.req_ready, 1'b1);
    bus.req_op    = op;
    bus.req_rn    = rn;
    bus.req_rm    = rm;
    bus.req_rd    = rd;
    bus.req_wb    = wb;
    bus.req_shift = sh;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("busy_after_accept", bus.busy, 1'b1);
    if (poke) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 3'd3;
      bus.wr_data = 16'(~ref_rf[3]);
    end
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(negedge clk);
      bus.wr_en = 1'b0;
      lat++;
    end
    bus.wr_en = 1'b0;
    check("latency", lat, 5);
    check("rsp_result", bus.rsp_result, e[15:0]);
    check("rsp_status", bus.rsp_status, e[18:16]);
    check("req_ready_in_resp", bus.req_ready, 1'b0);
    if (wb) ref_rf[rd] = e[15:0];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", bus.rsp_valid, 1'b1);
      check("hold_result", bus.rsp_result, e[15:0]);
      check("hold_req_ready", bus.req_ready, 1'b0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("rsp_valid_drop", bus.rsp_valid, 1'b0);
    check("busy_drop", bus.busy, 1'b0);
  endtask

  task automatic read_all_regs();
    for (int r = 0; r < 8; r++) begin
      run_op(2'd2, 3'(r), 3'(r), 3'd0, 1'b0, 2'd0, 0, 1'b0);
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_rn    = '0;
    bus.req_rm    = '0;
    bus.req_rd    = '0;
    bus.req_wb    = 1'b0;
    bus.req_shift = '0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.rsp_ready = 1'b0;
    for (int r = 0; r < 8; r++) ref_rf[r] = 16'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_rsp_valid", bus.rsp_valid, 1'b0);
    check("reset_req_ready", bus.req_ready, 1'b1);
    check("reset_rsp_result", bus.rsp_result, 16'd0);
    check("reset_rsp_status", bus.rsp_status, 3'd0);

    // ADD 5+3 into R2, then R2+R2
    ext_write(3'd0, 16'd5);
    ext_write(3'd1, 16'd3);
    run_op(2'd0, 3'd0, 3'd1, 3'd2, 1'b1, 2'd0, 0, 1'b0);
    check("add_const", bus.rsp_result, 16'd8);
    run_op(2'd0, 3'd2, 3'd2, 3'd5, 1'b1, 2'd0, 0, 1'b0);
    check("add_alias_const", bus.rsp_result, 16'd16);

    // SUB 3-5 without write-back, with a 4-cycle response stall
    ext_write(3'd0, 16'd3);
    ext_write(3'd1, 16'd5);
    run_op(2'd1, 3'd0, 3'd1, 3'd4, 1'b0, 2'd0, 4, 1'b0);
    check("sub_const", bus.rsp_result, 16'hFFFE);
    check("sub_status_const", bus.rsp_status, 3'b001);
    run_op(2'd2, 3'd4, 3'd4, 3'd0, 1'b0, 2'd0, 0, 1'b0);
    check("rd_unchanged", bus.rsp_result, 16'd0);

    // write during LOADA ignored; write alongside a request takes priority
    ext_write(3'd3, 16'h1234);
    run_op(2'd0, 3'd0, 3'd1, 3'd6, 1'b1, 2'd0, 0, 1'b1);
    run_op(2'd2, 3'd3, 3'd3, 3'd0, 1'b0, 2'd0, 0, 1'b0);
    check("r3_unchanged", bus.rsp_result, 16'h1234);
    @(negedge clk);
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 3'd7;
    bus.wr_data   = 16'hBEEF;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'd0;
    #1 check("wr_blocks_ready", bus.req_ready, 1'b0);
    @(negedge clk);
    bus.wr_en     = 1'b0;
    bus.req_valid = 1'b0;
    check("wr_no_accept", bus.busy, 1'b0);
    ref_rf[7] = 16'hBEEF;
    run_op(2'd2, 3'd7, 3'd7, 3'd0, 1'b0, 2'd0, 0, 1'b0);

    // NOT-B with arithmetic right shift code
    ext_write(3'd1, 16'h8001);
    run_op(2'd3, 3'd0, 3'd1, 3'd0, 1'b0, 2'd3, 0, 1'b0);
`ifdef ALU_SEQ_SHIFTER_EN
    check("notb_shift_const", bus.rsp_result, 16'h3FFF);
`else
    check("notb_shift_const", bus.rsp_result, 16'h7FFE);
`endif

    // randomized operations and writes
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        ext_write(3'($urandom_range(0, 7)), 16'($urandom));
      end else begin
        run_op(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               int'($urandom_range(0, 2)), 1'b0);
      end
    end
    read_all_regs();

    // reset while in EXEC clears everything
    @(negedge clk);
    bus.req_op    = 2'd0;
    bus.req_rn    = 3'd0;
    bus.req_rm    = 3'd1;
    bus.req_rd    = 3'd2;
    bus.req_wb    = 1'b1;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_reset_busy", bus.busy, 1'b0);
    check("mid_reset_rsp_valid", bus.rsp_valid, 1'b0);
    check("mid_reset_req_ready", bus.req_ready, 1'b1);
    check("mid_reset_rsp_result", bus.rsp_result, 16'd0);
    check("mid_reset_rsp_status", bus.rsp_status, 3'd0);
    check("mid_reset_alu_ain", bus.alu_ain, 16'd0);
    check("mid_reset_alu_op", bus.alu_op, 2'd0);
    for (int r = 0; r < 8; r++) ref_rf[r] = 16'd0;
    read_all_regs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
